// File: rtl/auto_vendor_pkg.sv
// auto_vendor_pkg
// Shared definitions for the vending-machine controller: FSM state encoding,
// coin/command codes on inputMoney, product codes on choose and/or give,
// and the fixed product prices.
package auto_vendor_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,  // accepting coins
        ST_VEND    = 2'd1,  // one-cycle dispense
        ST_REFUND  = 2'd2,  // one-cycle cancel/refund
        ST_HOLD    = 2'd3   // waiting for choose to be released
    } state_t;

    // Coin / command codes
    localparam logic [7:0] COIN_NONE   = 8'd0;
    localparam logic [7:0] COIN_CANCEL = 8'd2;
    localparam logic [7:0] COIN_C1     = 8'd1;
    localparam logic [7:0] COIN_C5     = 8'd5;
    localparam logic [7:0] COIN_C10    = 8'd10;
    localparam logic [7:0] COIN_C50    = 8'd50;

    // Product codes
    localparam logic [3:0] PROD_NONE   = 4'd0;
    localparam logic [3:0] PROD_TEA    = 4'd1;
    localparam logic [3:0] PROD_COLA   = 4'd2;
    localparam logic [3:0] PROD_COFFEE = 4'd3;
    localparam logic [3:0] PROD_MILK   = 4'd4;

    // Prices
    localparam logic [7:0] PRICE_TEA    = 8'd10;
    localparam logic [7:0] PRICE_COLA   = 8'd15;
    localparam logic [7:0] PRICE_COFFEE = 8'd20;
    localparam logic [7:0] PRICE_MILK   = 8'd25;

    // True for the four codes that carry coin value.
    function automatic logic is_coin(input logic [7:0] code);
        return (code == COIN_C1) || (code == COIN_C5) ||
               (code == COIN_C10) || (code == COIN_C50);
    endfunction

endpackage

// File: rtl/vendor_price_lut.sv
// vendor_price_lut
// Combinational map from a product select code to its price.
// Ports:
//   choose_i  product code (0 = none, 1..4 = products, 5..15 invalid)
//   valid_o   high when choose_i names a real product
//   price_o   price of that product (0 when not valid)
module vendor_price_lut
    import auto_vendor_pkg::*;
(
    input  logic [3:0] choose_i,
    output logic       valid_o,
    output logic [7:0] price_o
);

    always_comb begin
        valid_o = 1'b1;
        price_o = 8'd0;
        case (choose_i)
            PROD_TEA:    price_o = PRICE_TEA;
            PROD_COLA:   price_o = PRICE_COLA;
            PROD_COFFEE: price_o = PRICE_COFFEE;
            PROD_MILK:   price_o = PRICE_MILK;
            default:     valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/auto_vendor.sv
// auto_vendor
// Vending-machine controller: accumulates coin credit, vends a product when
// the credit covers its price (returning change), and refunds on cancel.
// All outputs are registered; give/change are single-cycle pulses.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   inputMoney  coin/command code (0 none, 1/5/10/50 coin, 2 cancel)
//   choose      product select (0 none, 1..4 products)
//   give        product being dispensed this cycle, 0 otherwise
//   change      coins returned this cycle, 0 otherwise
//   totalMoney  current accumulated credit
module auto_vendor
    import auto_vendor_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] inputMoney,
    input  logic [3:0] choose,
    output logic [3:0] give,
    output logic [7:0] change,
    output logic [7:0] totalMoney
);

    state_t     state_q, state_d;
    logic [3:0] give_q, give_d;
    logic [7:0] change_q, change_d;
    logic [7:0] total_q, total_d;

    logic       price_valid;
    logic [7:0] price;
    logic [8:0] coin_sum;

    vendor_price_lut u_price_lut (
        .choose_i (choose),
        .valid_o  (price_valid),
        .price_o  (price)
    );

    // One extra bit so a coin that would push credit past 255 is detectable.
    assign coin_sum = {1'b0, total_q} + {1'b0, inputMoney};

    always_comb begin
        state_d  = state_q;
        give_d   = PROD_NONE;
        change_d = 8'd0;
        total_d  = total_q;

        case (state_q)
            ST_COLLECT: begin
                // A non-zero choose outranks any coin or cancel in the same cycle.
                if (choose != PROD_NONE) begin
                    if (price_valid && (total_q >= price)) begin
                        state_d  = ST_VEND;
                        give_d   = choose;
                        change_d = total_q - price;
                        total_d  = 8'd0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (inputMoney == COIN_CANCEL) begin
                    state_d  = ST_REFUND;
                    change_d = total_q;
                    total_d  = 8'd0;
                end else if (is_coin(inputMoney) && !coin_sum[8]) begin
                    total_d = coin_sum[7:0];
                end
            end
            // The VEND cycle always passes through HOLD so a held choose
            // cannot trigger a second purchase.
            ST_VEND:   state_d = ST_HOLD;
            ST_REFUND: state_d = ST_COLLECT;
            ST_HOLD: begin
                if (choose == PROD_NONE) begin
                    state_d = ST_COLLECT;
                end
            end
            default:   state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_COLLECT;
            give_q   <= PROD_NONE;
            change_q <= 8'd0;
            total_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            give_q   <= give_d;
            change_q <= change_d;
            total_q  <= total_d;
        end
    end

    assign give       = give_q;
    assign change     = change_q;
    assign totalMoney = total_q;

endmodule

// File: tb/tb_auto_vendor.sv
// tb_auto_vendor
// Directed-vector bench for auto_vendor with hand-computed expected values.
module tb_auto_vendor;

    logic       clk;
    logic       reset;
    logic [7:0] inputMoney;
    logic [3:0] choose;
    logic [3:0] give;
    logic [7:0] change;
    logic [7:0] totalMoney;

    int tests_run;
    int tests_failed;

    auto_vendor dut (
        .clk        (clk),
        .reset      (reset),
        .inputMoney (inputMoney),
        .choose     (choose),
        .give       (give),
        .change     (change),
        .totalMoney (totalMoney)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Apply inputs, clock once, then settle past the edge before sampling.
    task automatic step(input logic [7:0] money, input logic [3:0] sel);
        inputMoney = money;
        choose     = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [7:0] money);
        step(money, 4'd0);
    endtask

    // Drop choose and spend enough cycles to return to COLLECT after a vend.
    task automatic release_sel();
        step(8'd0, 4'd0);
        step(8'd0, 4'd0);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eg,
                              input logic [7:0] ec, input logic [7:0] et);
        check({tag, ".give"},   {28'd0, give},       {28'd0, eg});
        check({tag, ".change"}, {24'd0, change},     {24'd0, ec});
        check({tag, ".total"},  {24'd0, totalMoney}, {24'd0, et});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        inputMoney   = 8'd0;
        choose       = 4'd0;
        reset        = 1'b1;
        @(negedge clk);
        step(8'd10, 4'd3);          // reset wins over simultaneous input
        check_outs("reset", 4'd0, 8'd0, 8'd0);
        reset = 1'b0;

        // Coins 10,1,10 then coffee held for three cycles.
        coin(8'd10); coin(8'd1); coin(8'd10);
        check("credit21", {24'd0, totalMoney}, 32'd21);
        step(8'd0, 4'd3);
        check_outs("vend_coffee", 4'd3, 8'd1, 8'd0);
        step(8'd0, 4'd3);
        check_outs("held1", 4'd0, 8'd0, 8'd0);
        step(8'd10, 4'd3);          // coin while choose held: in HOLD, ignored
        check_outs("held2", 4'd0, 8'd0, 8'd0);
        release_sel();

        // Coins 5,10 then cancel.
        coin(8'd5); coin(8'd10);
        check("credit15", {24'd0, totalMoney}, 32'd15);
        coin(8'd2);
        check_outs("refund", 4'd0, 8'd15, 8'd0);
        coin(8'd0);
        check("refund_end.change", {24'd0, change}, 32'd0);

        // Exact price: 10,10,1x5 then milk.
        coin(8'd10); coin(8'd10);
        for (int i = 0; i < 5; i++) coin(8'd1);
        check("credit25", {24'd0, totalMoney}, 32'd25);
        step(8'd0, 4'd4);
        check_outs("vend_milk", 4'd4, 8'd0, 8'd0);
        release_sel();

        // Insufficient credit, then top up and buy tea.
        coin(8'd10); coin(8'd10);
        step(8'd0, 4'd4);
        check_outs("short_milk", 4'd0, 8'd0, 8'd20);
        step(8'd0, 4'd0);
        coin(8'd10);
        check("credit30", {24'd0, totalMoney}, 32'd30);
        step(8'd0, 4'd1);
        check_outs("vend_tea", 4'd1, 8'd20, 8'd0);
        release_sel();

        // Coin 50 then coffee.
        coin(8'd50);
        step(8'd0, 4'd3);
        check_outs("vend_coffee50", 4'd3, 8'd30, 8'd0);
        release_sel();

        // Unknown code 7 ignored.
        coin(8'd7);
        check("code7", {24'd0, totalMoney}, 32'd0);

        // Overflow boundary.
        for (int i = 0; i < 5; i++) coin(8'd50);
        check("credit250", {24'd0, totalMoney}, 32'd250);
        coin(8'd10);
        check("reject10", {24'd0, totalMoney}, 32'd250);
        coin(8'd5);
        check("credit255", {24'd0, totalMoney}, 32'd255);
        coin(8'd1);
        check("reject1", {24'd0, totalMoney}, 32'd255);
        coin(8'd2);
        check_outs("refund255", 4'd0, 8'd255, 8'd0);
        coin(8'd0);

        // Invalid product code 9 goes to HOLD; coin while holding ignored.
        step(8'd0, 4'd9);
        check_outs("invalid9", 4'd0, 8'd0, 8'd0);
        step(8'd5, 4'd9);
        check("hold_coin", {24'd0, totalMoney}, 32'd0);
        step(8'd0, 4'd0);

        // Cola purchase, reset during HOLD, then fresh coin.
        coin(8'd10); coin(8'd10);
        step(8'd0, 4'd2);
        check_outs("vend_cola", 4'd2, 8'd5, 8'd0);
        step(8'd0, 4'd2);           // now in HOLD
        reset = 1'b1;
        step(8'd0, 4'd2);
        check_outs("reset_hold", 4'd0, 8'd0, 8'd0);
        reset = 1'b0;
        coin(8'd5);
        check("after_reset5", {24'd0, totalMoney}, 32'd5);

        // Purchase with coin in same cycle: choose wins, short credit -> HOLD.
        step(8'd10, 4'd1);
        check_outs("choose_prio", 4'd0, 8'd0, 8'd5);
        step(8'd0, 4'd0);
        coin(8'd5);
        check("after_hold10", {24'd0, totalMoney}, 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
